// File: rtl/rx_frame_loader.sv
// Frame loader: stores one IMG_W*IMG_H byte frame from the UART receiver
// into the image RAM, then starts the down-sampler and waits for it.
module rx_frame_loader #(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 1000000,
  parameter int TO_W    = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              ds_done,
  input  logic              err_clr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ds_start,
  output logic              loading,
  output logic              ds_busy,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] START = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  localparam int TOTAL = IMG_W * IMG_H;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(TOTAL - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

  logic              s1, s2, s3;
  logic              byte_evt;
  logic [1:0]        state;
  logic [ADDR_W:0]   count;
  logic [TO_W-1:0]   to_cnt;
  logic              set_ovr;
  logic              set_to;

  // rx_done lives in the receiver's tick domain; only its rising edge matters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= rx_done;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign byte_evt = s2 & ~s3;

  assign set_ovr = byte_evt & ((state == START) | (state == WAIT));
  assign set_to  = (state == LOAD) & ~byte_evt & (to_cnt == TO_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      to_cnt    <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= 1'b0;
      unique case (state)
        IDLE: begin
          to_cnt <= '0;
          if (byte_evt) begin
            ram_we    <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= rx_data;
            count     <= (ADDR_W+1)'(1);
            state     <= (LAST == '0) ? START : LOAD;
          end
        end
        LOAD: begin
          if (byte_evt) begin
            ram_we    <= 1'b1;
            ram_addr  <= count[ADDR_W-1:0];
            ram_wdata <= rx_data;
            count     <= count + 1'b1;
            to_cnt    <= '0;
            if (count == LAST) state <= START;
          end else if (to_cnt == TO_MAX) begin
            to_cnt <= '0;
            count  <= '0;
            state  <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        START: begin
          to_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          to_cnt <= '0;
          if (ds_done) begin
            count <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // a flag being set in the same cycle as err_clr stays set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (set_ovr) err_overrun <= 1'b1;
      else if (err_clr) err_overrun <= 1'b0;
      if (set_to) err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

  assign loading  = (state == LOAD);
  assign ds_start = (state == START);
  assign ds_busy  = (state == START) | (state == WAIT);

endmodule

// File: tb/tb_rx_frame_loader.sv
// Bench for rx_frame_loader: table-driven first frame, corner sequences,
// then random traffic checked against a frame-level model.
module tb_rx_frame_loader;

  localparam int W = 4;
  localparam int H = 2;
  localparam int TOTAL = W * H;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_done;
  logic [7:0]    rx_data;
  logic          ds_done;
  logic          err_clr;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ds_start;
  logic          loading;
  logic          ds_busy;
  logic          err_overrun;
  logic          err_timeout;

  rx_frame_loader #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .TIMEOUT(50), .TO_W(6)
  ) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
    .ds_done(ds_done), .err_clr(err_clr), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ds_start(ds_start),
    .loading(loading), .ds_busy(ds_busy), .err_overrun(err_overrun),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // pulse monitors
  int n_we = 0;
  int n_start = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) n_we++;
      if (ds_start) n_start++;
    end
  end

  // frame-level model
  int m_cnt = 0;
  bit m_busy = 0;
  bit m_ovr = 0;
  bit m_to = 0;
  int m_we = 0;
  int m_start = 0;
  int quiet = 0;

  typedef struct {
    logic [7:0] d;
    int         hold;
    int         addr;
    bit         start;
    bit         load;
  } vec_t;

  vec_t tab [TOTAL];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_byte(input int hold, input bit clr,
                            output bit ew, output int ea,
                            output bit es, output bit el);
    if (clr) begin
      m_ovr = 0;
      m_to = 0;
    end
    ew = 0; ea = 0; es = 0; el = 0;
    if (m_busy) begin
      m_ovr = 1;
      quiet += hold + 3;
    end else begin
      ew = 1;
      ea = m_cnt;
      m_cnt++;
      m_we++;
      quiet = hold;
      if (m_cnt == TOTAL) begin
        es = 1;
        m_busy = 1;
        m_start++;
      end else begin
        el = 1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int hold,
                           input bit clr, output logic we,
                           output logic [AW-1:0] a, output logic [7:0] wd,
                           output logic st, output logic ld);
    rx_data = d;
    rx_done = 1'b1;
    @(posedge clk); #1;
    chk("no_early_we1", 32'(ram_we), 32'd0);
    @(posedge clk); #1;
    chk("no_early_we2", 32'(ram_we), 32'd0);
    err_clr = clr;
    @(posedge clk); #1;
    we = ram_we;
    a = ram_addr;
    wd = ram_wdata;
    st = ds_start;
    ld = loading;
    err_clr = 1'b0;
    if (hold > 3) begin
      repeat (hold - 3) @(posedge clk);
      #1;
    end
    rx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string nm);
    chk({nm, "_busy"}, 32'(ds_busy), 32'(m_busy));
    chk({nm, "_loading"}, 32'(loading), 32'(!m_busy && m_cnt > 0));
    chk({nm, "_ovr"}, 32'(err_overrun), 32'(m_ovr));
    chk({nm, "_to"}, 32'(err_timeout), 32'(m_to));
    chk({nm, "_nwe"}, 32'(n_we), 32'(m_we));
    chk({nm, "_nstart"}, 32'(n_start), 32'(m_start));
  endtask

  task automatic byte_chk(input string nm, input logic [7:0] d,
                          input int hold, input bit clr);
    logic we, st, ld;
    logic [AW-1:0] a;
    logic [7:0] wd;
    bit ew, es, el;
    int ea;
    send_byte(d, hold, clr, we, a, wd, st, ld);
    model_byte(hold, clr, ew, ea, es, el);
    chk({nm, "_we"}, 32'(we), 32'(ew));
    if (ew) begin
      chk({nm, "_addr"}, 32'(a), 32'(ea));
      chk({nm, "_data"}, 32'(wd), 32'(d));
      chk({nm, "_start"}, 32'(st), 32'(es));
      chk({nm, "_load"}, 32'(ld), 32'(el));
    end
    check_state(nm);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
    quiet += n;
    if (quiet >= 60 && m_cnt > 0 && !m_busy) begin
      m_to = 1;
      m_cnt = 0;
    end
  endtask

  task automatic done_pulse();
    ds_done = 1'b1;
    @(posedge clk); #1;
    ds_done = 1'b0;
    quiet += 1;
    if (m_busy) begin
      m_busy = 0;
      m_cnt = 0;
    end
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    quiet += 1;
    m_ovr = 0;
    m_to = 0;
  endtask

  task automatic frame(input string nm, input logic [7:0] base);
    for (int i = 0; i < TOTAL; i++)
      byte_chk(nm, base + 8'(i), 4, 1'b0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_we"}, 32'(ram_we), 32'd0);
    chk({nm, "_addr"}, 32'(ram_addr), 32'd0);
    chk({nm, "_wdata"}, 32'(ram_wdata), 32'd0);
    chk({nm, "_start"}, 32'(ds_start), 32'd0);
    chk({nm, "_loading"}, 32'(loading), 32'd0);
    chk({nm, "_busy"}, 32'(ds_busy), 32'd0);
    chk({nm, "_ovr"}, 32'(err_overrun), 32'd0);
    chk({nm, "_to"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic we, st, ld;
    logic [AW-1:0] a;
    logic [7:0] wd;
    bit ew, es, el;
    int ea;
    for (int i = 0; i < TOTAL; i++)
      tab[i] = '{8'h10 + 8'(i), (i == 2) ? 20 : 4, i, i == TOTAL - 1,
                 i != TOTAL - 1};

    rst = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    ds_done = 1'b0;
    err_clr = 1'b0;
    #2;
    check_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // first frame from the table; byte 2 holds rx_done for 20 clks
    for (int i = 0; i < TOTAL; i++) begin
      send_byte(tab[i].d, tab[i].hold, 1'b0, we, a, wd, st, ld);
      model_byte(tab[i].hold, 1'b0, ew, ea, es, el);
      chk("tab_we", 32'(we), 32'd1);
      chk("tab_addr", 32'(a), 32'(tab[i].addr));
      chk("tab_data", 32'(wd), 32'(tab[i].d));
      chk("tab_start", 32'(st), 32'(tab[i].start));
      chk("tab_load", 32'(ld), 32'(tab[i].load));
    end
    check_state("tab_end");
    chk("tab_start_off", 32'(ds_start), 32'd0);
    done_pulse();
    check_state("tab_done");

    // inter-byte timeout, then a clean frame
    for (int i = 0; i < 3; i++) byte_chk("to_pre", 8'hA0 + 8'(i), 4, 1'b0);
    idle(70);
    check_state("to_abort");
    frame("to_next", 8'h40);
    done_pulse();
    check_state("to_done");

    // overrun while the down-sampler is busy
    frame("ovr_fill", 8'h50);
    byte_chk("ovr_byte", 8'hEE, 4, 1'b0);
    done_pulse();
    check_state("ovr_done");
    clr_pulse();
    check_state("ovr_clr");
    frame("ovr_fill2", 8'h60);
    byte_chk("ovr_setwins", 8'hDD, 4, 1'b1);
    done_pulse();
    clr_pulse();
    check_state("ovr_clr2");

    // async reset mid-frame
    for (int i = 0; i < 5; i++) byte_chk("rst_pre", 8'h70 + 8'(i), 4, 1'b0);
    #2 rst = 1'b1;
    #1 check_zero("rst_mid");
    m_cnt = 0; m_busy = 0; m_ovr = 0; m_to = 0;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    frame("rst_next", 8'h80);
    done_pulse();
    check_state("rst_done");

    // ds_done during LOAD is ignored
    for (int i = 0; i < 3; i++) byte_chk("dsl_pre", 8'h90 + 8'(i), 4, 1'b0);
    done_pulse();
    check_state("dsl_ign");
    for (int i = 3; i < TOTAL; i++)
      byte_chk("dsl_rest", 8'h90 + 8'(i), 4, 1'b0);
    done_pulse();
    check_state("dsl_done");

    // random traffic
    for (int k = 0; k < 300; k++) begin
      int op;
      op = $urandom_range(0, 19);
      if (quiet > 30 && m_cnt > 0 && !m_busy) op = 16;
      if (op < 14)
        byte_chk("rnd_byte", 8'($urandom), $urandom_range(3, 6),
                 $urandom_range(0, 7) == 0);
      else if (op < 16) begin
        done_pulse();
        check_state("rnd_done");
      end else if (op == 16) begin
        idle(70);
        check_state("rnd_idle");
      end else if (op == 17) begin
        clr_pulse();
        check_state("rnd_clr");
      end else begin
        idle($urandom_range(0, 5));
        check_state("rnd_gap");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
